// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
// Exposes the next-step quotient/remainder so the final step can be written back directly.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // rem < dsr always holds, so the difference fits in WIDTH bits when fits=1
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsr});
    diff    = shifted[WIDTH-1:0] - dsr;
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; WIDTH-cycle data-independent latency.
// Divider is built only when MDU_DIVIDER_EN is defined; otherwise DIV/DIVU are no-ops.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               last;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mcand;
  logic               neg_res;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

`ifdef MDU_DIVIDER_EN
  logic               neg_rem;
  logic               div_zero;
  logic               div_load;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;

  assign div_load = (state == IDLE) && start && ((op == OP_DIV) || (op == OP_DIVU));

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (state == DIV),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );
`endif

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
  end

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    product  = neg_res ? -mul_next : mul_next;
  end

  assign last = (cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: state_next = MUL;
`ifdef MDU_DIVIDER_EN
            OP_DIV, OP_DIVU:   state_next = DIV;
`endif
            default:           state_next = IDLE;
          endcase
        end
      end
      MUL:     if (last) state_next = IDLE;
      DIV:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      neg_res <= 1'b0;
`ifdef MDU_DIVIDER_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc     <= {{WIDTH{1'b0}}, abs_a};
                mcand   <= abs_b;
                neg_res <= a_neg ^ b_neg;
                cnt     <= CW'(WIDTH);
              end
              OP_DIV, OP_DIVU: begin
`ifdef MDU_DIVIDER_EN
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
                cnt      <= CW'(WIDTH);
`else
                done     <= 1'b1;
`endif
              end
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          acc <= mul_next;
          if (last) begin
            hi   <= product[2*WIDTH-1:WIDTH];
            lo   <= product[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt - 1'b1;
`ifdef MDU_DIVIDER_EN
          // Divide by zero leaves rem = |a|, which the sign fix turns back into a
          if (last) begin
            hi   <= neg_rem ? -rem_next : rem_next;
            lo   <= div_zero ? '1 : (neg_res ? -quo_next : quo_next);
            done <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; DIV expectations follow MDU_DIVIDER_EN.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request before edge E0; returns at the falling edge after E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done, bounded; tracks busy and HI/LO holding meanwhile.
  task automatic wait_done(output int n, output bit busy_ok, output bit hold_ok);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  int n, n2;
  bit busy_ok, hold_ok, seen_done;
  logic [31:0] exp_hi, exp_lo, exp_lat;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // MULTU 0xFFFFFFFF * 2
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_busy_e0", {31'b0, busy}, 32'd1);
    wait_done(n, busy_ok, hold_ok);
    check("multu_latency", n, 32'd32);
    check("multu_busy_hold", {31'b0, busy_ok}, 32'd1);
    check("multu_hilo_hold", {31'b0, hold_ok}, 32'd1);
    check("multu_busy_end", {31'b0, busy}, 32'd0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    @(negedge clk);
    check("multu_done_1cyc", {31'b0, done}, 32'd0);

    // MULT -3 * 5, then MTHI
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(n, busy_ok, hold_ok);
    check("mult_latency", n, 32'd32);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'hFFFF_FFF1);
    check("mthi_done", {31'b0, done}, 32'd1);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mthi_done_1cyc", {31'b0, done}, 32'd0);
    issue(OP_MTLO, 32'h0000_5678, 32'd0);
    check("mtlo_lo", lo, 32'h0000_5678);
    check("mtlo_hi", hi, 32'h0000_1234);
    @(negedge clk);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, busy_ok, hold_ok);
`ifdef MDU_DIVIDER_EN
    exp_lat = 32; exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`else
    exp_lat = 0;  exp_hi = 32'h0000_1234; exp_lo = 32'h0000_5678;
`endif
    check("div_latency", n, exp_lat);
    check("div_busy_hold", {31'b0, busy_ok}, 32'd1);
    check("div_hi", hi, exp_hi);
    check("div_lo", lo, exp_lo);
    check("div_busy_end", {31'b0, busy}, 32'd0);
    @(negedge clk);

    // DIV signed overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, busy_ok, hold_ok);
`ifdef MDU_DIVIDER_EN
    exp_hi = 32'h0; exp_lo = 32'h8000_0000;
`endif
    check("divovf_latency", n, exp_lat);
    check("divovf_hi", hi, exp_hi);
    check("divovf_lo", lo, exp_lo);
    @(negedge clk);

    // DIVU 7 / 0
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(n, busy_ok, hold_ok);
`ifdef MDU_DIVIDER_EN
    exp_hi = 32'd7; exp_lo = 32'hFFFF_FFFF;
`endif
    check("divz_latency", n, exp_lat);
    check("divz_hi", hi, exp_hi);
    check("divz_lo", lo, exp_lo);
    @(negedge clk);

    // MULTU 6*7 with an ignored second request at E5
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(n2, busy_ok, hold_ok);
    check("ign_latency", n2 + 5, 32'd32);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd42);
    repeat (3) @(negedge clk);
    check("ign_no_queue_busy", {31'b0, busy}, 32'd0);
    check("ign_lo_after", lo, 32'd42);

    // Reserved op code
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    check("rsv_done", {31'b0, done}, 32'd0);
    check("rsv_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("rsv_done_late", {31'b0, done}, 32'd0);
    check("rsv_lo", lo, 32'd42);

    // Back-to-back: request during the done cycle is accepted
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(n, busy_ok, hold_ok);
    check("b2b_first_lo", lo, 32'd12);
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done(n, busy_ok, hold_ok);
    check("b2b_latency", n, 32'd32);
    check("b2b_lo", lo, 32'd25);
    @(negedge clk);

    // Reset during MULT at E10
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
